// File: rtl/jt12_acc_gen.sv
// jt12_acc_gen: FM operator accumulator with combined and per-channel outputs.
//
// Sums the operator output (or PCM on the last channel) of every slot into two
// continuous left/right round sums. It also keeps a per-channel partial-sum
// buffer that produces a time-multiplexed per-channel stream.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clk_en            slot advance; every state update is qualified by it
//   op_result [WIN]   signed operator output of the current slot
//   rl [2]            [1] left enable, [0] right enable of the current channel
//   limiter_en        1: saturate sums, 0: wrap
//   zero              first slot of a round (S1 of channel 0)
//   s1..s4_enters     operator slot flags
//   ch6op             current slot belongs to channel NUM_CH-1
//   alg [3]           algorithm of the current channel
//   pcm_en, pcm [WIN] PCM (offset binary) replaces FM on the last channel
//   left, right       signed combined round sums (WOUT bits)
//   mux_left/right    signed per-channel sums (WIN bits)
//   mux_sample        one-slot pulse marking a new per-channel sample
module jt12_acc_gen #(
  parameter int WIN    = 9,
  parameter int WOUT   = 12,
  parameter int NUM_CH = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [WIN-1:0]  op_result,
  input  logic [1:0]      rl,
  input  logic            limiter_en,
  input  logic            zero,
  input  logic            s1_enters,
  input  logic            s2_enters,
  input  logic            s3_enters,
  input  logic            s4_enters,
  input  logic            ch6op,
  input  logic [2:0]      alg,
  input  logic            pcm_en,
  input  logic [WIN-1:0]  pcm,
  output logic [WOUT-1:0] left,
  output logic [WOUT-1:0] right,
  output logic [WIN-1:0]  mux_left,
  output logic [WIN-1:0]  mux_right,
  output logic            mux_sample
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Four operator contributions of WIN bits never overflow WIN+2 bits.
  localparam int WB = WIN + 2;

  localparam logic [WOUT-1:0] OUT_MAX = {1'b0, {(WOUT-1){1'b1}}};
  localparam logic [WOUT-1:0] OUT_MIN = {1'b1, {(WOUT-1){1'b0}}};
  localparam logic [WIN-1:0]  WIN_MAX = {1'b0, {(WIN-1){1'b1}}};
  localparam logic [WIN-1:0]  WIN_MIN = {1'b1, {(WIN-1){1'b0}}};

  // The slot counter is kept as a channel counter plus a group counter,
  // which avoids dividing by NUM_CH when it is not a power of two.
  logic [CW-1:0] ch_reg, ch_next, ch_cur;
  logic [1:0]    grp_reg, grp_next, grp_cur;

  logic          sum_en, use_pcm;
  logic [WIN-1:0]  in_val, contrib;
  logic [WOUT-1:0] contrib_out;
  logic [WB-1:0]   contrib_wb;

  logic [WOUT-1:0] acc_l_reg, acc_r_reg;
  logic [WOUT-1:0] acc_l_add, acc_r_add;

  logic [WB-1:0]   buf_vec [NUM_CH];
  logic [WB-1:0]   buf_rd, buf_sum;
  logic [WIN-1:0]  buf_red;

  // Saturating / wrapping add of a WIN-bit contribution to a WOUT-bit sum.
  function automatic logic [WOUT-1:0] add_out(input logic [WOUT-1:0] a,
                                              input logic [WOUT-1:0] b,
                                              input logic            lim);
    logic [WOUT:0] s;
    s = {a[WOUT-1], a} + {b[WOUT-1], b};
    if (lim && (s[WOUT] != s[WOUT-1]))
      add_out = s[WOUT] ? OUT_MIN : OUT_MAX;
    else
      add_out = s[WOUT-1:0];
  endfunction

  // Slot position: zero forces slot 0 for the current cycle.
  always_comb begin
    ch_cur  = zero ? '0 : ch_reg;
    grp_cur = zero ? 2'd0 : grp_reg;
    if (ch_cur == CW'(NUM_CH - 1)) begin
      ch_next  = '0;
      grp_next = grp_cur + 2'd1;   // group 3 wraps back to group 0
    end else begin
      ch_next  = ch_cur + CW'(1);
      grp_next = grp_cur;
    end
  end

  // Contribution of the current slot.
  always_comb begin
    case (alg)
      3'd0, 3'd1, 3'd2, 3'd3: sum_en = s4_enters;
      3'd4:                   sum_en = s2_enters | s4_enters;
      3'd5, 3'd6:             sum_en = ~s1_enters;
      default:                sum_en = 1'b1;
    endcase
    use_pcm     = ch6op & pcm_en;
    in_val      = use_pcm ? {~pcm[WIN-1], pcm[WIN-2:0]} : op_result;
    contrib     = (sum_en | use_pcm) ? in_val : '0;
    contrib_out = {{(WOUT-WIN){contrib[WIN-1]}}, contrib};
    contrib_wb  = {{(WB-WIN){contrib[WIN-1]}}, contrib};
    acc_l_add   = add_out(acc_l_reg, contrib_out, limiter_en);
    acc_r_add   = add_out(acc_r_reg, contrib_out, limiter_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_reg  <= '0;
      grp_reg <= '0;
    end else if (clk_en) begin
      ch_reg  <= ch_next;
      grp_reg <= grp_next;
    end
  end

  // Combined path: on zero the finished round is published and the
  // accumulator restarts from this slot's contribution.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l_reg <= '0;
      acc_r_reg <= '0;
      left      <= '0;
      right     <= '0;
    end else if (clk_en) begin
      if (zero) begin
        left      <= acc_l_reg;
        right     <= acc_r_reg;
        acc_l_reg <= rl[1] ? contrib_out : '0;
        acc_r_reg <= rl[0] ? contrib_out : '0;
      end else begin
        if (rl[1]) acc_l_reg <= acc_l_add;
        if (rl[0]) acc_r_reg <= acc_r_add;
      end
    end
  end

  // Per-channel partial-sum buffer, one register per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_buf
    logic [WB-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (clk_en && (ch_cur == CW'(gi))) begin
        if (grp_cur == 2'd0)
          entry_reg <= contrib_wb;
        else if (grp_cur != 2'd3)
          entry_reg <= buf_sum;
      end
    end
    assign buf_vec[gi] = entry_reg;
  end

  always_comb begin
    buf_rd  = buf_vec[ch_cur];
    buf_sum = buf_rd + contrib_wb;
    // The sum fits WIN bits only when the top three bits agree.
    if (limiter_en && !((buf_sum[WB-1] == buf_sum[WB-2]) &&
                        (buf_sum[WB-2] == buf_sum[WB-3])))
      buf_red = buf_sum[WB-1] ? WIN_MIN : WIN_MAX;
    else
      buf_red = buf_sum[WIN-1:0];
  end

  // Mux outputs: one sample per channel during the S4 group.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_left   <= '0;
      mux_right  <= '0;
      mux_sample <= 1'b0;
    end else if (clk_en) begin
      if (grp_cur == 2'd3) begin
        mux_left   <= rl[1] ? buf_red : '0;
        mux_right  <= rl[0] ? buf_red : '0;
        mux_sample <= 1'b1;
      end else begin
        mux_sample <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jt12_acc_gen.sv
// Testbench for jt12_acc_gen: directed rounds with hand-computed expected
// sums pushed into queues; a monitor compares each published output.
module tb_jt12_acc_gen;
  localparam int WIN = 9, WOUT = 12, NUM_CH = 6;

  logic clk = 1'b0;
  logic rst, clk_en, limiter_en, zero, ch6op, pcm_en;
  logic s1_enters, s2_enters, s3_enters, s4_enters;
  logic [WIN-1:0] op_result, pcm;
  logic [1:0] rl;
  logic [2:0] alg;
  logic [WOUT-1:0] left, right;
  logic [WIN-1:0] mux_left, mux_right;
  logic mux_sample;

  jt12_acc_gen #(.WIN(WIN), .WOUT(WOUT), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_result(op_result), .rl(rl),
    .limiter_en(limiter_en), .zero(zero), .s1_enters(s1_enters),
    .s2_enters(s2_enters), .s3_enters(s3_enters), .s4_enters(s4_enters),
    .ch6op(ch6op), .alg(alg), .pcm_en(pcm_en), .pcm(pcm), .left(left),
    .right(right), .mux_left(mux_left), .mux_right(mux_right),
    .mux_sample(mux_sample)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int q_l[$], q_r[$], q_ml[$], q_mr[$];
  int pend_l = 0, pend_r = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT published on an enabled edge.
  initial begin
    bit ce, zq;
    forever begin
      @(posedge clk);
      ce = clk_en && !rst;
      zq = ce && zero;
      @(negedge clk);
      if (zq) begin
        if (q_l.size() == 0) check("left_unexpected", 1, 0);
        else begin
          check("left", int'($signed(left)), q_l.pop_front());
          check("right", int'($signed(right)), q_r.pop_front());
        end
      end
      if (ce && mux_sample) begin
        if (q_ml.size() == 0) check("mux_sample_unexpected", 1, 0);
        else begin
          check("mux_left", int'($signed(mux_left)), q_ml.pop_front());
          check("mux_right", int'($signed(mux_right)), q_mr.pop_front());
        end
      end
    end
  end

  task automatic drive_slot(input int slot, input logic z);
    int g, c;
    g = slot / NUM_CH;
    c = slot % NUM_CH;
    clk_en = 1'b1;
    zero = z;
    s1_enters = (g == 0);
    s3_enters = (g == 1);
    s2_enters = (g == 2);
    s4_enters = (g == 3);
    ch6op = (c == NUM_CH - 1);
    @(posedge clk); #1;
  endtask

  // One round of nslots slots starting with zero. gap_at >= 0 inserts
  // 5 cycles of clk_en=0 before that slot, with noise on the inputs.
  task automatic run_round(input int nslots, input int el, input int er,
                           input int eml, input int emr, input int eml5,
                           input int emr5, input int gap_at);
    logic [WIN-1:0] op_keep;
    for (int s = 0; s < nslots; s++) begin
      if (s == 0) begin
        q_l.push_back(pend_l);
        q_r.push_back(pend_r);
      end
      if (s == gap_at) begin
        op_keep = op_result;
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
          zero = 1'b1;
          op_result = WIN'($urandom);
          @(posedge clk); #1;
        end
        // Held values: previous round sum and the last channel sample.
        check("gap_left_hold", int'($signed(left)), pend_l);
        check("gap_mux_left_hold", int'($signed(mux_left)), eml);
        check("gap_mux_sample_hold", int'(mux_sample), 1);
        op_result = op_keep;
      end
      if (s >= 3 * NUM_CH) begin
        q_ml.push_back((s % NUM_CH == NUM_CH - 1) ? eml5 : eml);
        q_mr.push_back((s % NUM_CH == NUM_CH - 1) ? emr5 : emr);
      end
      drive_slot(s, s == 0);
    end
    pend_l = el;
    pend_r = er;
  endtask

  task automatic cfg(input logic [2:0] a, input int op, input logic [1:0] r,
                     input logic lim, input logic pe, input logic [WIN-1:0] p);
    alg = a;
    op_result = WIN'(op);
    rl = r;
    limiter_en = lim;
    pcm_en = pe;
    pcm = p;
  endtask

  initial begin
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clk_en = 1'b1; zero = 1'($urandom); op_result = WIN'($urandom);
      rl = 2'b11; limiter_en = 1'($urandom); alg = 3'($urandom);
      s1_enters = 1'($urandom); s2_enters = 1'($urandom);
      s3_enters = 1'($urandom); s4_enters = 1'($urandom);
      ch6op = 1'($urandom); pcm_en = 1'($urandom); pcm = WIN'($urandom);
      @(posedge clk); #1;
    end
    check("rst_left", int'(left), 0);
    check("rst_right", int'(right), 0);
    check("rst_mux_left", int'(mux_left), 0);
    check("rst_mux_right", int'(mux_right), 0);
    check("rst_mux_sample", int'(mux_sample), 0);
    rst = 1'b0;

    cfg(3'd7, 10, 2'b11, 1'b1, 1'b0, '0);
    run_round(24, 240, 240, 40, 40, 40, 40, -1);
    cfg(3'd0, 100, 2'b11, 1'b1, 1'b0, '0);
    run_round(24, 600, 600, 100, 100, 100, 100, -1);
    cfg(3'd7, 255, 2'b11, 1'b1, 1'b0, '0);
    run_round(24, 2047, 2047, 255, 255, 255, 255, -1);
    cfg(3'd7, 255, 2'b11, 1'b0, 1'b0, '0);
    run_round(24, 2024, 2024, -4, -4, -4, -4, -1);
    cfg(3'd0, 0, 2'b11, 1'b1, 1'b1, 9'h1FF);
    run_round(24, 1020, 1020, 0, 0, 255, 255, -1);
    cfg(3'd0, 0, 2'b11, 1'b1, 1'b1, 9'h000);
    run_round(24, -1024, -1024, 0, 0, -256, -256, -1);
    cfg(3'd7, 10, 2'b10, 1'b1, 1'b0, '0);
    run_round(24, 240, 0, 40, 0, 40, 0, -1);
    cfg(3'd7, 10, 2'b11, 1'b1, 1'b0, '0);
    run_round(24, 240, 240, 40, 40, 40, 40, 20);
    run_round(10, 100, 100, 0, 0, 0, 0, -1);
    run_round(24, 240, 240, 40, 40, 40, 40, -1);

    // Final zero slot publishes the last round.
    q_l.push_back(pend_l);
    q_r.push_back(pend_r);
    cfg(3'd7, 0, 2'b11, 1'b1, 1'b0, '0);
    drive_slot(0, 1'b1);
    clk_en = 1'b0;
    zero = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pending_round_sums", q_l.size(), 0);
    check("pending_mux_samples", q_ml.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
